bf16_mul_issue: RTL and testbench
=================================

Name: bf16_mul_issue

Overview:
- Operand front-end that sits directly upstream of the combinational BF16 multiplier stage (FP16ALT, RNE, zero pipe registers).
- Accepts independent A and B operand streams via valid/ready and buffers each in a small FIFO.
- Pairs FIFO heads in order, drives the multiplier inputs from a register, and captures the returned product into a registered valid/ready output.
- Provides full-throughput (one product per cycle) streaming with backpressure around a multiplier that has no handshake of its own.

Parameters:
DEPTH, 4, entries per operand FIFO; power of two, >= 2
LVL_W, $clog2(DEPTH)+1, width of the fill-level outputs (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of FIFOs and pipeline; same effect as rst
a_valid  in  1  A operand valid
a_ready  out  1  A FIFO can accept
a_data  in  16  A operand, BF16
b_valid  in  1  B operand valid
b_ready  out  1  B FIFO can accept
b_data  in  16  B operand, BF16
mul_a  out  16  to multiplier inA, registered
mul_b  out  16  to multiplier inB, registered
mul_result  in  16  from multiplier out, combinational function of mul_a/mul_b
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out_data  out  16  BF16 product
a_level  out  LVL_W  A FIFO occupancy
b_level  out  LVL_W  B FIFO occupancy

Behaviour:
- Reset/flush values: a_ready=b_ready=1 on the cycle after release; out_valid=0; out_data=0; mul_a=mul_b=0; levels=0; issue-valid=0. Flush has priority over any same-cycle push or pop; data in flight is discarded.
- FIFOs: push on valid&ready. ready = (level != DEPTH); no push-on-full even if a pop occurs in the same cycle. An entry written at the edge ending cycle t is poppable in cycle t+1 (no fall-through). Pointers wrap modulo DEPTH. A simultaneous push and pop leaves the level unchanged.
- Pairing: pop both heads together only when both are non-empty and the issue stage can load. A lone A or B waits indefinitely; there is no timeout.
- Issue stage: a register {iss_valid, mul_a, mul_b}. adv_out = !out_valid | out_ready. The issue stage loads when (!iss_valid | adv_out); iss_valid is cleared if it was consumed with no new pair. mul_a/mul_b hold their value while not advancing.
- Capture: when iss_valid & adv_out, the output register loads out_data<=mul_result and out_valid<=1. Otherwise, if out_ready, out_valid<=0. out_data is held stable while out_valid & !out_ready.
- Latency: operand pair accepted in cycle 0 -> pop in cycle 1 -> mul_a/mul_b valid in cycle 2 -> out_valid in cycle 3. Throughput is 1 per cycle with out_ready tied high.
- Ordering: products leave strictly in the order of pairing, with no reordering or drops except on rst/flush.
- Reset mid-operation: all queued and in-flight operands are lost; there is no partial output.

Optional Feature:
- Macro BF16_MUL_ISSUE_FTZ_EN.
- Defined: at the pop-to-issue boundary, any operand with exponent==0 and mantissa!=0 is replaced by a zero of the same sign (0x0000/0x8000) before loading mul_a/mul_b. FIFO contents are untouched.
- Undefined: operands pass bit-exact.

Decomposition:
- Package bf16_mul_pkg: bf16_t (16-bit packed struct sign/exp[7:0]/man[6:0]), BF16_ZERO/BF16_NEG_ZERO constants, is_subnormal function.
- Sub-module bf16_stream_fifo (DEPTH, 16-bit data, valid/ready push, pop/empty, level), instantiated once per stream.

Test Plan:
- Single pair: A=0x3FC0 (1.5), B=0x4040 (3.0), out_ready=1 -> out_valid in cycle 3 with out_data=0x4090 (4.5); mul_a=0x3FC0 and mul_b=0x4040 in cycle 2.
- Skew: four A values pushed, no B -> a_level=4, a_ready=0, no pop, out_valid=0. Then push B=0x3F80 ×4 -> four products equal to the A values, in order.
- Backpressure: stream 8 pairs with out_ready held 0 -> out_valid=1 holding the first product stable, issue stage holds, FIFOs fill to DEPTH and deassert ready. Release out_ready -> all 8 products emerge in order with no duplicates.
- Full throughput: 16 pairs (A=0x4000, B=i·0x0080+0x3F80) with valid and out_ready constant 1 -> one output per cycle after 3-cycle fill.
- Flush mid-stream: 3 pairs in flight, assert flush for one cycle -> next cycle out_valid=0, levels=0, no stale product later.
- FTZ (macro defined): A=0x8001, B=0x3F80 -> mul_a=0x8000, out_data=0x8000. Without the macro -> mul_a=0x8001.

Source files
------------

// File: rtl/bf16_mul_pkg.sv
// Shared BF16 types and helpers for the multiplier issue front-end.
// Optional flush-to-zero of subnormal operands is selected with BF16_MUL_ISSUE_FTZ_EN.
package bf16_mul_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    localparam bf16_t BF16_ZERO     = '{sign: 1'b0, exp: 8'h00, man: 7'h00};
    localparam bf16_t BF16_NEG_ZERO = '{sign: 1'b1, exp: 8'h00, man: 7'h00};

    function automatic logic is_subnormal(input bf16_t v);
        return (v.exp == 8'h00) && (v.man != 7'h00);
    endfunction

    // Replace a subnormal by a zero carrying the same sign.
    function automatic bf16_t flush_subnormal(input bf16_t v);
        if (is_subnormal(v)) begin
            return v.sign ? BF16_NEG_ZERO : BF16_ZERO;
        end
        return v;
    endfunction

endpackage

// File: rtl/bf16_stream_fifo.sv
// Small register-array FIFO for one BF16 operand stream: valid/ready push,
// pop/empty read side with the head visible the cycle after it is written.
module bf16_stream_fifo
    import bf16_mul_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [15:0]      push_data,
    input  logic             pop,
    output logic             empty,
    output logic [15:0]      head,
    output logic [LVL_W-1:0] level
);

    logic [15:0]      mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             push_fire;
    logic             pop_fire;

    // Ready depends only on the current level: a full FIFO refuses even when popping.
    assign push_ready = (level_reg != LVL_W'(DEPTH));
    assign empty      = (level_reg == '0);
    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = pop & ~empty;
    assign head       = mem_reg[rd_ptr_reg];
    assign level      = level_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_fire && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/bf16_mul_issue.sv
// Operand front-end for a combinational BF16 multiplier: per-stream FIFOs,
// in-order pairing, registered issue and output stages. Macro: BF16_MUL_ISSUE_FTZ_EN.
module bf16_mul_issue
    import bf16_mul_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [15:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [15:0]      b_data,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    input  logic [15:0]      mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [LVL_W-1:0] a_level,
    output logic [LVL_W-1:0] b_level
);

    logic        clear;
    logic        a_empty;
    logic        b_empty;
    logic [15:0] a_head;
    logic [15:0] b_head;
    logic        pair_pop;
    logic        adv_out;
    logic        iss_load;
    bf16_t       op_a;
    bf16_t       op_b;

    logic        iss_valid_reg;
    logic [15:0] mul_a_reg;
    logic [15:0] mul_b_reg;
    logic        out_valid_reg;
    logic [15:0] out_data_reg;

    assign clear = rst | flush;

    bf16_stream_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk        (clk),
        .srst       (clear),
        .push_valid (a_valid),
        .push_ready (a_ready),
        .push_data  (a_data),
        .pop        (pair_pop),
        .empty      (a_empty),
        .head       (a_head),
        .level      (a_level)
    );

    bf16_stream_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk        (clk),
        .srst       (clear),
        .push_valid (b_valid),
        .push_ready (b_ready),
        .push_data  (b_data),
        .pop        (pair_pop),
        .empty      (b_empty),
        .head       (b_head),
        .level      (b_level)
    );

    assign adv_out  = ~out_valid_reg | out_ready;
    assign iss_load = ~iss_valid_reg | adv_out;
    assign pair_pop = ~a_empty & ~b_empty & iss_load;

`ifdef BF16_MUL_ISSUE_FTZ_EN
    assign op_a = flush_subnormal(bf16_t'(a_head));
    assign op_b = flush_subnormal(bf16_t'(b_head));
`else
    assign op_a = bf16_t'(a_head);
    assign op_b = bf16_t'(b_head);
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            iss_valid_reg <= 1'b0;
            mul_a_reg     <= 16'h0000;
            mul_b_reg     <= 16'h0000;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 16'h0000;
        end else begin
            if (iss_load) begin
                iss_valid_reg <= pair_pop;
                if (pair_pop) begin
                    mul_a_reg <= op_a;
                    mul_b_reg <= op_b;
                end
            end
            // The multiplier has no handshake, so its result is taken the cycle its inputs are issued.
            if (iss_valid_reg && adv_out) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= mul_result;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_bf16_mul_issue.sv
// Self-checking bench for bf16_mul_issue with a behavioural BF16 multiplier and scoreboard.
module tb_bf16_mul_issue;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             a_valid = 1'b0;
    logic             a_ready;
    logic [15:0]      a_data = 16'h0;
    logic             b_valid = 1'b0;
    logic             b_ready;
    logic [15:0]      b_data = 16'h0;
    logic [15:0]      mul_a;
    logic [15:0]      mul_b;
    logic [15:0]      mul_result;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [LVL_W-1:0] a_level;
    logic [LVL_W-1:0] b_level;

    int checks = 0;
    int errors = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] obs[$];

    always #5 clk = ~clk;

    bf16_mul_issue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_data     (b_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .a_level    (a_level),
        .b_level    (b_level)
    );

    // Reference BF16 multiply, RNE, subnormal inputs treated as zero; stimulus stays in normal range.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [7:0]  ma;
        logic [7:0]  mb;
        logic [15:0] p;
        logic [6:0]  m;
        logic        g;
        logic        st;
        logic [14:0] em;
        s = a[15] ^ b[15];
        if (a[14:7] == 8'h00 || b[14:7] == 8'h00) return {s, 15'h0000};
        ma = {1'b1, a[6:0]};
        mb = {1'b1, b[6:0]};
        p  = 16'(ma) * 16'(mb);
        e  = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            e  = e + 1;
            m  = p[14:8];
            g  = p[7];
            st = |p[6:0];
        end else begin
            m  = p[13:7];
            g  = p[6];
            st = |p[5:0];
        end
        em = {e[7:0], m};
        if (g && (st || m[0])) em = em + 15'd1;
        return {s, em};
    endfunction

    function automatic logic [15:0] ftz_ref(input logic [15:0] v);
`ifdef BF16_MUL_ISSUE_FTZ_EN
        if (v[14:7] == 8'h00) return {v[15], 15'h0000};
`endif
        return v;
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        if (r[31:28] == 4'h0) return {r[0], 8'h00, 7'(r[7:1] | 7'h01)};
        return {r[0], 8'h70 + 8'(r[12:8]), r[19:13]};
    endfunction

    assign mul_result = ref_mul(mul_a, mul_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic da, input logic [15:0] va, input logic db, input logic [15:0] vb);
        int   n;
        logic acc_a;
        logic acc_b;
        n = 0;
        a_valid = da; a_data = va; b_valid = db; b_data = vb;
        while ((a_valid || b_valid) && n < 200) begin
            @(negedge clk);
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            tick();
            if (acc_a) a_valid = 1'b0;
            if (acc_b) b_valid = 1'b0;
            n++;
        end
        if (a_valid || b_valid) begin
            chk("push_timeout", 32'(n), 32'd0);
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
    endtask

    task automatic wait_obs(input int target, input int budget);
        int n;
        n = 0;
        while (obs.size() < target && n < budget) begin
            tick();
            n++;
        end
        chk("drain_count", 32'(obs.size()), 32'(target));
    endtask

    // Scoreboard: record accepted operands, pair them in order, check every accepted product.
    logic        hold_prev = 1'b0;
    logic [15:0] prev_data = 16'h0;
    initial begin
        logic [15:0] ea;
        logic [15:0] eb;
        forever begin
            @(negedge clk);
            if (rst || flush) begin
                qa.delete();
                qb.delete();
                hold_prev = 1'b0;
            end else begin
                chk("a_ready_vs_level", 32'(a_ready), 32'(a_level != LVL_W'(DEPTH)));
                chk("b_ready_vs_level", 32'(b_ready), 32'(b_level != LVL_W'(DEPTH)));
                if (hold_prev) begin
                    chk("out_hold_valid", 32'(out_valid), 32'd1);
                    chk("out_hold_data", 32'(out_data), 32'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (qa.size() == 0 || qb.size() == 0) begin
                        chk("spurious_output", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        ea = qa.pop_front();
                        eb = qb.pop_front();
                        chk("product", 32'(out_data), 32'(ref_mul(ftz_ref(ea), ftz_ref(eb))));
                    end
                    obs.push_back(out_data);
                end
                if (a_valid && a_ready) qa.push_back(a_data);
                if (b_valid && b_ready) qb.push_back(b_data);
                hold_prev = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          base;
        int          first;
        int          cnt;
        logic [15:0] av[8];
        logic [15:0] bv[8];
        logic [15:0] sk[4];

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_a_ready", 32'(a_ready), 32'd1);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_a_level", 32'(a_level), 32'd0);
        chk("rst_b_level", 32'(b_level), 32'd0);

        // Single pair latency: 1.5 * 3.0 = 4.5
        out_ready = 1'b1;
        a_valid = 1'b1; a_data = 16'h3FC0; b_valid = 1'b1; b_data = 16'h4040;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("single_a_level", 32'(a_level), 32'd1);
        chk("single_c1_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("single_mul_a", 32'(mul_a), 32'h3FC0);
        chk("single_mul_b", 32'(mul_b), 32'h4040);
        chk("single_c2_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_data", 32'(out_data), 32'h4090);
        tick();
        chk("single_out_clear", 32'(out_valid), 32'd0);

        // Skew: A only until full, then B = 1.0
        for (int i = 0; i < 4; i++) begin
            sk[i] = {1'b0, 8'h7C + 8'(i), 7'(i * 19 + 5)};
            push(1'b1, sk[i], 1'b0, 16'h0);
        end
        repeat (3) tick();
        chk("skew_a_level", 32'(a_level), 32'd4);
        chk("skew_a_ready", 32'(a_ready), 32'd0);
        chk("skew_b_level", 32'(b_level), 32'd0);
        chk("skew_out_valid", 32'(out_valid), 32'd0);
        base = obs.size();
        for (int i = 0; i < 4; i++) push(1'b0, 16'h0, 1'b1, 16'h3F80);
        wait_obs(base + 4, 40);
        for (int i = 0; i < 4; i++) begin
            if (base + i < obs.size()) chk("skew_order", 32'(obs[base + i]), 32'(sk[i]));
        end

        // Backpressure: 8 pairs with the consumer stalled
        out_ready = 1'b0;
        base = obs.size();
        for (int i = 0; i < 8; i++) begin
            av[i] = rnd_op();
            bv[i] = rnd_op();
        end
        fork
            begin
                for (int i = 0; i < 8; i++) push(1'b1, av[i], 1'b1, bv[i]);
            end
            begin
                repeat (20) tick();
                chk("bp_a_level", 32'(a_level), 32'(DEPTH));
                chk("bp_b_level", 32'(b_level), 32'(DEPTH));
                chk("bp_a_ready", 32'(a_ready), 32'd0);
                chk("bp_b_ready", 32'(b_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_first", 32'(out_data), 32'(ref_mul(ftz_ref(av[0]), ftz_ref(bv[0]))));
                out_ready = 1'b1;
            end
        join
        wait_obs(base + 8, 60);

        // Full throughput: 16 pairs back to back
        out_ready = 1'b1;
        first = -1;
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            if (k < 16) begin
                if (!(a_ready && b_ready)) chk("tp_ready", 32'({a_ready, b_ready}), 32'd3);
                a_valid = 1'b1; a_data = 16'h4000;
                b_valid = 1'b1; b_data = 16'(k * 16'h0080 + 16'h3F80);
            end else begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
            tick();
            if (out_valid) begin
                if (first < 0) first = k;
                cnt++;
            end
        end
        chk("tp_first_cycle", 32'(first), 32'd2);
        chk("tp_count", 32'(cnt), 32'd16);

        // Flush with three pairs in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b1, rnd_op(), 1'b1, rnd_op());
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_a_level", 32'(a_level), 32'd0);
        chk("flush_b_level", 32'(b_level), 32'd0);
        chk("flush_mul_a", 32'(mul_a), 32'd0);
        out_ready = 1'b1;
        base = obs.size();
        repeat (10) tick();
        chk("flush_no_stale", 32'(obs.size()), 32'(base));

        // Subnormal operand at the issue boundary
        push(1'b1, 16'h8001, 1'b1, 16'h3F80);
        tick();
`ifdef BF16_MUL_ISSUE_FTZ_EN
        chk("ftz_mul_a", 32'(mul_a), 32'h8000);
`else
        chk("ftz_mul_a", 32'(mul_a), 32'h8001);
`endif
        chk("ftz_mul_b", 32'(mul_b), 32'h3F80);
        tick();
        chk("ftz_out_valid", 32'(out_valid), 32'd1);
        chk("ftz_out_data", 32'(out_data), 32'h8000);

        // Random traffic with random backpressure and rare flushes
        for (int k = 0; k < 800; k++) begin
            a_valid   = ($urandom_range(0, 3) != 0);
            a_data    = rnd_op();
            b_valid   = ($urandom_range(0, 3) != 0);
            b_data    = rnd_op();
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 199) == 0);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (30) tick();
        chk("rand_no_stuck_pair", 32'((qa.size() < qb.size()) ? qa.size() : qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
